// File: rtl/crc_pkg.sv
// Shared types, legal parameter ranges and the single-bit CRC step used by crc_stream.
package crc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } crc_state_e;

  localparam int CRC_WIDTH_MIN  = 2;
  localparam int CRC_WIDTH_MAX  = 32;
  localparam int DATA_WIDTH_MIN = 1;
  localparam int DATA_WIDTH_MAX = 64;

  // Register and poly are aligned to bit 0 for right shifts and to bit 31 for
  // left shifts, so one 32-bit step serves every CRC width.
  function automatic logic [31:0] crc_step(input logic [31:0] crc_reg,
                                           input logic        data_bit,
                                           input logic [31:0] poly,
                                           input logic        shift_right);
    logic        fb;
    logic [31:0] nxt;
    if (shift_right) begin
      fb  = crc_reg[0] ^ data_bit;
      nxt = crc_reg >> 1;
    end else begin
      fb  = crc_reg[31] ^ data_bit;
      nxt = crc_reg << 1;
    end
    if (fb) nxt = nxt ^ poly;
    return nxt;
  endfunction

endpackage

// File: rtl/crc_word_update.sv
// Combinational next-register logic: DATA_WIDTH unrolled serial CRC steps per word.
module crc_word_update
  import crc_pkg::*;
#(
  parameter int                   CRC_WIDTH   = 16,
  parameter int                   DATA_WIDTH  = 8,
  parameter logic [CRC_WIDTH-1:0] POLY        = 16'hA001,
  parameter bit                   SHIFT_RIGHT = 1'b1
) (
  input  logic [CRC_WIDTH-1:0]  crc_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [CRC_WIDTH-1:0]  crc_out
);

  localparam logic [31:0] POLY_AL = SHIFT_RIGHT ? 32'(POLY) : (32'(POLY) << (32 - CRC_WIDTH));

  logic [31:0] acc;

  always_comb begin
    acc = SHIFT_RIGHT ? 32'(crc_in) : (32'(crc_in) << (32 - CRC_WIDTH));
    for (int i = 0; i < DATA_WIDTH; i++) begin
      acc = crc_step(acc, SHIFT_RIGHT ? data_in[i] : data_in[DATA_WIDTH-1-i], POLY_AL, SHIFT_RIGHT);
    end
    crc_out = SHIFT_RIGHT ? acc[CRC_WIDTH-1:0] : acc[31 -: CRC_WIDTH];
  end

endmodule

// File: rtl/crc_stream.sv
// Streaming CRC engine with ready/valid input and a held result.
// Optional residue check output crcOk is enabled by defining CRC_STREAM_CHECK_EN.
module crc_stream
  import crc_pkg::*;
#(
  parameter int                   CRC_WIDTH   = 16,
  parameter int                   DATA_WIDTH  = 8,
  parameter logic [CRC_WIDTH-1:0] POLY        = 16'hA001,
  parameter bit                   SHIFT_RIGHT = 1'b1,
  parameter logic [CRC_WIDTH-1:0] INIT        = '1,
  parameter logic [CRC_WIDTH-1:0] XOR_OUT     = '0,
  parameter logic [CRC_WIDTH-1:0] RESIDUE     = '0
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  start,
  input  logic                  inValid,
  output logic                  inReady,
  input  logic [DATA_WIDTH-1:0] inData,
  input  logic                  inLast,
  output logic                  outValid,
  input  logic                  outReady,
  output logic                  busy,
  output logic [CRC_WIDTH-1:0]  outCrc
`ifdef CRC_STREAM_CHECK_EN
  ,
  output logic                  crcOk
`endif
);

  if (CRC_WIDTH < CRC_WIDTH_MIN || CRC_WIDTH > CRC_WIDTH_MAX) begin : g_bad_crc_width
    $error("crc_stream: CRC_WIDTH out of range");
  end
  if (DATA_WIDTH < DATA_WIDTH_MIN || DATA_WIDTH > DATA_WIDTH_MAX) begin : g_bad_data_width
    $error("crc_stream: DATA_WIDTH out of range");
  end

  crc_state_e           state_q, state_d;
  logic [CRC_WIDTH-1:0] crc_q, crc_d, crc_next;
  logic                 alive_q, alive_d;
  logic                 beat;

  crc_word_update #(
    .CRC_WIDTH  (CRC_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .POLY       (POLY),
    .SHIFT_RIGHT(SHIFT_RIGHT)
  ) u_update (
    .crc_in (crc_q),
    .data_in(inData),
    .crc_out(crc_next)
  );

  assign beat = inValid && inReady;

  // The register always holds INIT in IDLE, so the first beat needs no special case.
  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    alive_d = 1'b1;
    if (start) begin
      state_d = IDLE;
      crc_d   = INIT;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (beat) begin
            crc_d   = crc_next;
            state_d = inLast ? HOLD : ACCUM;
          end
        end
        HOLD: begin
          if (outReady) begin
            state_d = IDLE;
            crc_d   = INIT;
          end
        end
        default: begin
          state_d = IDLE;
          crc_d   = INIT;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= IDLE;
      crc_q   <= INIT;
      alive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      alive_q <= alive_d;
    end
  end

  // Outputs decode straight from state so reset clears them without a clock.
  assign inReady  = alive_q && (state_q != HOLD);
  assign outValid = (state_q == HOLD);
  assign busy     = (state_q == ACCUM);
  assign outCrc   = outValid ? (crc_q ^ XOR_OUT) : '0;

`ifdef CRC_STREAM_CHECK_EN
  assign crcOk = outValid && (crc_q == RESIDUE);
`endif

endmodule

// File: tb/tb_crc_stream.sv
// Directed bench for crc_stream: CRC-16/MODBUS default instance plus a CRC-8 left-shift instance.
module tb_crc_stream;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        start = 1'b0;
  logic        inValid = 1'b0;
  logic [7:0]  inData = 8'h00;
  logic        inLast = 1'b0;
  logic        outReady = 1'b0;

  logic        inReady, outValid, busy;
  logic [15:0] outCrc;
  logic        inReady8, outValid8, busy8;
  logic [7:0]  outCrc8;
`ifdef CRC_STREAM_CHECK_EN
  logic        crcOk, crcOk8;
`endif

  int errors = 0;
  int checks = 0;

  logic [7:0] msg [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

  always #5 clk = ~clk;

  crc_stream dut (
    .clk(clk), .rstN(rstN), .start(start),
    .inValid(inValid), .inReady(inReady), .inData(inData), .inLast(inLast),
    .outValid(outValid), .outReady(outReady), .busy(busy), .outCrc(outCrc)
`ifdef CRC_STREAM_CHECK_EN
    , .crcOk(crcOk)
`endif
  );

  crc_stream #(
    .CRC_WIDTH(8), .DATA_WIDTH(8), .POLY(8'h07), .SHIFT_RIGHT(1'b0),
    .INIT(8'h00), .XOR_OUT(8'h00), .RESIDUE(8'h00)
  ) dut8 (
    .clk(clk), .rstN(rstN), .start(start),
    .inValid(inValid), .inReady(inReady8), .inData(inData), .inLast(inLast),
    .outValid(outValid8), .outReady(outReady), .busy(busy8), .outCrc(outCrc8)
`ifdef CRC_STREAM_CHECK_EN
    , .crcOk(crcOk8)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic last);
    @(negedge clk);
    inValid = 1'b1;
    inData  = d;
    inLast  = last;
    @(posedge clk);
    #1;
    inValid = 1'b0;
    inLast  = 1'b0;
  endtask

  task automatic sendMsg(input logic endFrame, input logic [7:0] flip);
    for (int i = 0; i < 9; i++) begin
      applyStimulus((i == 0) ? (msg[i] ^ flip) : msg[i], endFrame && (i == 8));
    end
  endtask

  task automatic takeResult(input string tag);
    @(negedge clk);
    outReady = 1'b1;
    @(posedge clk);
    #1;
    outReady = 1'b0;
    checkOutput(tag, 32'(outValid), 32'd0);
  endtask

  initial begin
    #2;
    checkOutput("reset_outValid", 32'(outValid), 32'd0);
    checkOutput("reset_outCrc",   32'(outCrc),   32'd0);
    checkOutput("reset_busy",     32'(busy),     32'd0);
    checkOutput("reset_inReady",  32'(inReady),  32'd0);
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("ready_after_reset", 32'(inReady), 32'd1);

    $display("[TB] basic frame and HOLD stall");
    sendMsg(1'b1, 8'h00);
    checkOutput("frame_valid", 32'(outValid), 32'd1);
    checkOutput("frame_crc16", 32'(outCrc), 32'h4B37);
    checkOutput("frame_crc8",  32'(outCrc8), 32'hF4);
    checkOutput("frame_busy",  32'(busy), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      inValid = 1'b1;
      inData  = 8'hFF;
      checkOutput("hold_crc",     32'(outCrc), 32'h4B37);
      checkOutput("hold_inReady", 32'(inReady), 32'd0);
    end
    @(negedge clk);
    inValid = 1'b0;
    checkOutput("hold_valid", 32'(outValid), 32'd1);
    takeResult("hold_release");
    sendMsg(1'b1, 8'h00);
    checkOutput("after_hold_crc", 32'(outCrc), 32'h4B37);
    takeResult("after_hold_release");

    $display("[TB] gaps inside a frame");
    for (int i = 0; i < 9; i++) begin
      applyStimulus(msg[i], i == 8);
      if (i < 8) begin
        @(negedge clk);
        checkOutput("gap_busy", 32'(busy), 32'd1);
      end
    end
    checkOutput("gap_crc", 32'(outCrc), 32'h4B37);
    takeResult("gap_release");

    $display("[TB] one-word frame");
    applyStimulus(8'h00, 1'b1);
    checkOutput("one_valid", 32'(outValid), 32'd1);
    checkOutput("one_busy",  32'(busy), 32'd0);
    checkOutput("one_crc16", 32'(outCrc), 32'h40BF);
    checkOutput("one_crc8",  32'(outCrc8), 32'h00);
    takeResult("one_release");

    $display("[TB] start abort mid-frame");
    for (int i = 0; i < 4; i++) applyStimulus(msg[i], 1'b0);
    @(negedge clk);
    inValid = 1'b1;
    inData  = 8'h35;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    inValid = 1'b0;
    checkOutput("start_busy",  32'(busy), 32'd0);
    checkOutput("start_valid", 32'(outValid), 32'd0);
    sendMsg(1'b1, 8'h00);
    checkOutput("start_next_crc16", 32'(outCrc), 32'h4B37);
    checkOutput("start_next_crc8",  32'(outCrc8), 32'hF4);

    @(negedge clk);
    start    = 1'b1;
    outReady = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    outReady = 1'b0;
    checkOutput("start_hold_valid", 32'(outValid), 32'd0);
    checkOutput("start_hold_ready", 32'(inReady), 32'd1);

    $display("[TB] reset mid-frame and in HOLD");
    for (int i = 0; i < 3; i++) applyStimulus(msg[i], 1'b0);
    @(negedge clk);
    rstN = 1'b0;
    #1;
    checkOutput("rst_mid_busy",  32'(busy), 32'd0);
    checkOutput("rst_mid_ready", 32'(inReady), 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #1;
    sendMsg(1'b1, 8'h00);
    checkOutput("rst_mid_next_crc", 32'(outCrc), 32'h4B37);
    @(negedge clk);
    rstN = 1'b0;
    #1;
    checkOutput("rst_hold_valid", 32'(outValid), 32'd0);
    checkOutput("rst_hold_crc",   32'(outCrc), 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_hold_after", 32'(outValid), 32'd0);
    sendMsg(1'b1, 8'h00);
    checkOutput("rst_hold_next_crc", 32'(outCrc), 32'h4B37);
    takeResult("rst_hold_release");

`ifdef CRC_STREAM_CHECK_EN
    $display("[TB] residue check");
    sendMsg(1'b0, 8'h00);
    applyStimulus(8'h37, 1'b0);
    applyStimulus(8'h4B, 1'b1);
    checkOutput("residue_ok",  32'(crcOk), 32'd1);
    checkOutput("residue_crc", 32'(outCrc), 32'h0000);
    takeResult("residue_release");
    sendMsg(1'b0, 8'h01);
    applyStimulus(8'h37, 1'b0);
    applyStimulus(8'h4B, 1'b1);
    checkOutput("corrupt_ok", 32'(crcOk), 32'd0);
    takeResult("corrupt_release");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
